mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 54 +++++
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_arbiter.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_if
// Brief    : IFU/LSU request-response channels and the shared memory port.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [63:0] ifu_addr;
    logic        ifu_resp_valid;
    logic [63:0] ifu_rdata;
    logic        ifu_resp_err;

    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic [63:0] lsu_addr;
    logic        lsu_wen;
    logic [63:0] lsu_wdata;
    logic [7:0]  lsu_wmask;
    logic        lsu_resp_valid;
    logic [63:0] lsu_rdata;
    logic        lsu_resp_err;

    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_addr;
    logic        mem_wen;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_resp_valid;
    logic [63:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  ifu_req_valid, ifu_addr,
        output ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
        input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        output lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        input  mem_req_ready, mem_resp_valid, mem_rdata
    );

    // Requester / memory side
    modport master (
        output ifu_req_valid, ifu_addr,
        input  ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
        output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        input  lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        output mem_req_ready, mem_resp_valid, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Two-requester (IFU/LSU) single-outstanding memory arbiter with
//            alternating priority and request/response timeout.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);

    // One spare count above TIMEOUT so a request accepted exactly at the
    // limit still times out on its first WAIT cycle instead of wrapping.
    localparam int CNT_W = $clog2(TIMEOUT + 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [CNT_W-1:0] cnt;
    logic        last_grant;   // 1 = LSU
    logic        owner;        // 1 = LSU
    logic [63:0] lat_addr;
    logic        lat_wen;
    logic [63:0] lat_wdata;
    logic [7:0]  lat_wmask;
    logic [63:0] ifu_rdata_q;
    logic        ifu_err_q;
    logic [63:0] lsu_rdata_q;
    logic        lsu_err_q;

    logic grant_ifu;
    logic grant_lsu;
    logic timed_out;
    logic accept;
    logic complete;
    logic expire;
    logic req_valid;

    assign grant_ifu = bus.ifu_req_valid && (!bus.lsu_req_valid || last_grant);
    assign grant_lsu = bus.lsu_req_valid && (!bus.ifu_req_valid || !last_grant);
    assign timed_out = (cnt >= CNT_W'(TIMEOUT));

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        complete   = 1'b0;
        expire     = 1'b0;
        req_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (grant_ifu || grant_lsu) begin
                    accept     = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                req_valid = 1'b1;
                if (bus.mem_req_ready) begin
                    state_next = WAIT;
                end else if (timed_out) begin
                    expire     = 1'b1;
                    state_next = RESP;
                end
            end
            WAIT: begin
                if (bus.mem_resp_valid) begin
                    complete   = 1'b1;
                    state_next = RESP;
                end else if (timed_out) begin
                    expire     = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            last_grant  <= 1'b0;
            owner       <= 1'b0;
            lat_addr    <= '0;
            lat_wen     <= 1'b0;
            lat_wdata   <= '0;
            lat_wmask   <= '0;
            ifu_rdata_q <= '0;
            ifu_err_q   <= 1'b0;
            lsu_rdata_q <= '0;
            lsu_err_q   <= 1'b0;
        end else begin
            state <= state_next;

            if (accept) begin
                owner      <= grant_lsu;
                last_grant <= grant_lsu;
                lat_addr   <= grant_lsu ? bus.lsu_addr  : bus.ifu_addr;
                lat_wen    <= grant_lsu & bus.lsu_wen;
                lat_wdata  <= grant_lsu ? bus.lsu_wdata : '0;
                lat_wmask  <= grant_lsu ? bus.lsu_wmask : '0;
            end

            if (accept) begin
                cnt <= '0;
            end else if (state == REQ || state == WAIT) begin
                cnt <= cnt + CNT_W'(1);
            end

            // Each channel keeps its own copy so it holds between responses.
            if (complete || expire) begin
                if (owner) begin
                    lsu_rdata_q <= complete ? bus.mem_rdata : '0;
                    lsu_err_q   <= expire;
                end else begin
                    ifu_rdata_q <= complete ? bus.mem_rdata : '0;
                    ifu_err_q   <= expire;
                end
            end
        end
    end

    assign bus.ifu_req_ready  = (state == IDLE) && grant_ifu;
    assign bus.lsu_req_ready  = (state == IDLE) && grant_lsu;

    assign bus.mem_req_valid  = req_valid;
    assign bus.mem_addr       = req_valid ? lat_addr  : '0;
    assign bus.mem_wen        = req_valid & lat_wen;
    assign bus.mem_wdata      = req_valid ? lat_wdata : '0;
    assign bus.mem_wmask      = req_valid ? lat_wmask : '0;

    assign bus.ifu_resp_valid = (state == RESP) && !owner;
    assign bus.ifu_rdata      = ifu_rdata_q;
    assign bus.ifu_resp_err   = ifu_err_q;
    assign bus.lsu_resp_valid = (state == RESP) && owner;
    assign bus.lsu_rdata      = lsu_rdata_q;
    assign bus.lsu_resp_err   = lsu_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Directed plus randomized checks of mem_arbiter against a
//            transaction-level timing model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int T = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_err    = 0;

    // Reference model state
    bit          last_lsu = 1'b0;
    logic [63:0] exp_ifu_rdata = '0;
    logic        exp_ifu_err   = 1'b0;
    logic [63:0] exp_lsu_rdata = '0;
    logic        exp_lsu_err   = 1'b0;

    mem_arbiter_if bus ();

    mem_arbiter #(.TIMEOUT(T)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_held(input string tag);
        chk({tag, "_ifu_rdata"}, bus.ifu_rdata,    exp_ifu_rdata);
        chk({tag, "_ifu_err"},   bus.ifu_resp_err, exp_ifu_err);
        chk({tag, "_lsu_rdata"}, bus.lsu_rdata,    exp_lsu_rdata);
        chk({tag, "_lsu_err"},   bus.lsu_resp_err, exp_lsu_err);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_mem_valid"}, bus.mem_req_valid,  0);
        chk({tag, "_mem_addr"},  bus.mem_addr,       0);
        chk({tag, "_mem_wen"},   bus.mem_wen,        0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata,      0);
        chk({tag, "_mem_wmask"}, bus.mem_wmask,      0);
        chk({tag, "_ifu_rv"},    bus.ifu_resp_valid, 0);
        chk({tag, "_lsu_rv"},    bus.lsu_resp_valid, 0);
    endtask

    task automatic idle_inputs();
        bus.ifu_req_valid  = 1'b0;
        bus.lsu_req_valid  = 1'b0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
    endtask

    task automatic noise_requesters();
        bus.ifu_req_valid = 1'($urandom_range(0, 1));
        bus.lsu_req_valid = 1'($urandom_range(0, 1));
        bus.ifu_addr      = {$urandom, $urandom};
        bus.lsu_addr      = {$urandom, $urandom};
        bus.lsu_wen       = 1'($urandom_range(0, 1));
        bus.lsu_wdata     = {$urandom, $urandom};
        bus.lsu_wmask     = 8'($urandom);
    endtask

    // One full transaction. d1 = REQ cycles before mem_req_ready, d2 = WAIT
    // cycles before mem_resp_valid. Cycle k counts from the first REQ cycle.
    task automatic txn(input bit iv, input bit lv, input logic [63:0] ia,
                       input logic [63:0] la, input bit lw, input logic [63:0] lwd,
                       input logic [7:0] lm, input int d1, input int d2,
                       input logic [63:0] rd);
        bit          win_lsu;
        logic [63:0] ea, ewd;
        bit          ewen;
        logic [7:0]  em;
        int          rsp, tlim, fin;
        bit          err, in_req;

        @(posedge clk); #1;
        bus.ifu_req_valid  = iv;
        bus.lsu_req_valid  = lv;
        bus.ifu_addr       = ia;
        bus.lsu_addr       = la;
        bus.lsu_wen        = lw;
        bus.lsu_wdata      = lwd;
        bus.lsu_wmask      = lm;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'($urandom_range(0, 1));
        bus.mem_rdata      = {$urandom, $urandom};
        @(negedge clk);
        win_lsu = lv && (!iv || !last_lsu);
        chk("acc_ifu_ready", bus.ifu_req_ready, iv && !win_lsu);
        chk("acc_lsu_ready", bus.lsu_req_ready, win_lsu);
        chk_quiet("acc");
        chk_held("acc_hold");
        last_lsu = win_lsu;

        ea   = win_lsu ? la : ia;
        ewen = win_lsu && lw;
        ewd  = win_lsu ? lwd : 64'd0;
        em   = win_lsu ? lm : 8'd0;
        rsp  = d1 + 1 + d2;
        tlim = (d1 >= T) ? d1 + 1 : T;
        if (d1 > T) begin
            fin = T; err = 1'b1;
        end else if (rsp <= tlim) begin
            fin = rsp; err = 1'b0;
        end else begin
            fin = tlim; err = 1'b1;
        end

        for (int k = 0; k <= fin; k++) begin
            in_req = (k <= d1);
            @(posedge clk); #1;
            noise_requesters();
            bus.mem_req_ready  = (k == d1) ? 1'b1 : (in_req ? 1'b0 : 1'($urandom_range(0, 1)));
            bus.mem_resp_valid = (k == rsp) ? 1'b1 : (in_req ? 1'($urandom_range(0, 1)) : 1'b0);
            bus.mem_rdata      = (k == rsp) ? rd : {$urandom, $urandom};
            @(negedge clk);
            chk("busy_mem_valid", bus.mem_req_valid, in_req);
            chk("busy_mem_addr",  bus.mem_addr,  in_req ? ea  : 64'd0);
            chk("busy_mem_wen",   bus.mem_wen,   in_req ? ewen : 1'b0);
            chk("busy_mem_wdata", bus.mem_wdata, in_req ? ewd : 64'd0);
            chk("busy_mem_wmask", bus.mem_wmask, in_req ? em  : 8'd0);
            chk("busy_ifu_ready", bus.ifu_req_ready, 0);
            chk("busy_lsu_ready", bus.lsu_req_ready, 0);
            chk("busy_ifu_rv",    bus.ifu_resp_valid, 0);
            chk("busy_lsu_rv",    bus.lsu_resp_valid, 0);
        end

        @(posedge clk); #1;
        noise_requesters();
        bus.mem_req_ready  = 1'($urandom_range(0, 1));
        bus.mem_resp_valid = 1'($urandom_range(0, 1));
        bus.mem_rdata      = {$urandom, $urandom};
        @(negedge clk);
        if (win_lsu) begin
            exp_lsu_rdata = err ? 64'd0 : rd;
            exp_lsu_err   = err;
        end else begin
            exp_ifu_rdata = err ? 64'd0 : rd;
            exp_ifu_err   = err;
        end
        chk("resp_ifu_rv", bus.ifu_resp_valid, !win_lsu);
        chk("resp_lsu_rv", bus.lsu_resp_valid, win_lsu);
        chk("resp_mem_valid", bus.mem_req_valid, 0);
        chk("resp_ifu_ready", bus.ifu_req_ready, 0);
        chk("resp_lsu_ready", bus.lsu_req_ready, 0);
        chk_held("resp");
    endtask

    initial begin
        bit          iv, lv;
        int          r;
        logic [63:0] a;

        idle_inputs();
        bus.ifu_addr  = '0;
        bus.lsu_addr  = '0;
        bus.lsu_wen   = 1'b0;
        bus.lsu_wdata = '0;
        bus.lsu_wmask = '0;
        bus.mem_rdata = '0;

        // Reset state
        repeat (3) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk_quiet("rst");
            chk_held("rst");
            chk("rst_ifu_ready", bus.ifu_req_ready, 0);
            chk("rst_lsu_ready", bus.lsu_req_ready, 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        // Both valid straight after reset: LSU, IFU, LSU, IFU
        for (int i = 0; i < 4; i++) begin
            txn(1, 1, 64'h100 + 64'(i), 64'h200 + 64'(i), 1'(i), {$urandom, $urandom},
                8'($urandom), 0, 0, {$urandom, $urandom});
            chk("alternate_grant", last_lsu, (i % 2) == 0);
        end

        // Minimum-latency IFU read
        txn(1, 0, 64'h8000_0000, 64'd0, 0, 64'd0, 8'd0, 0, 0, 64'h0000_0413_0000_0297);
        // LSU write with ready held low 3 cycles (response lands at the limit)
        txn(0, 1, 64'd0, 64'h8000_1000, 1, 64'hDEAD_BEEF_CAFE_F00D, 8'h0F, 3, 0,
            64'h1111_2222_3333_4444);
        // Memory never responds -> timeout error, then a normal request
        txn(1, 0, 64'h8000_0040, 64'd0, 0, 64'd0, 8'd0, 0, 50, 64'hBAD0_BAD0_BAD0_BAD0);
        txn(1, 0, 64'h8000_0080, 64'd0, 0, 64'd0, 8'd0, 1, 0, 64'h5555_6666_7777_8888);
        // Response on the exact cycle the counter reaches TIMEOUT
        txn(0, 1, 64'd0, 64'h9000_0000, 0, 64'd0, 8'd0, 0, 3, 64'hA5A5_A5A5_5A5A_5A5A);
        // Timeout while still in REQ
        txn(0, 1, 64'd0, 64'h9000_0008, 1, 64'h77, 8'hFF, 6, 0, 64'h0123_4567_89AB_CDEF);
        // Ready exactly at the limit, then prompt and late responses
        txn(1, 0, 64'h9000_0010, 64'd0, 0, 64'd0, 8'd0, T, 0, 64'hFEED_FACE_0000_0001);
        txn(1, 0, 64'h9000_0018, 64'd0, 0, 64'd0, 8'd0, T, 1, 64'hFEED_FACE_0000_0002);

        // Reset pulse while in WAIT; later stray response must be ignored
        @(posedge clk); #1;
        bus.ifu_req_valid  = 1'b1;
        bus.lsu_req_valid  = 1'b0;
        bus.ifu_addr       = 64'hC000_0000;
        bus.mem_resp_valid = 1'b0;
        @(negedge clk);
        chk("wr_acc_ready", bus.ifu_req_ready, 1);
        @(posedge clk); #1;
        bus.ifu_req_valid = 1'b0;
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        chk("wr_req_valid", bus.mem_req_valid, 1);
        chk("wr_req_addr",  bus.mem_addr, 64'hC000_0000);
        @(posedge clk); #1;
        bus.mem_req_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("wr_wait_valid", bus.mem_req_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        last_lsu      = 1'b0;
        exp_ifu_rdata = '0;
        exp_ifu_err   = 1'b0;
        exp_lsu_rdata = '0;
        exp_lsu_err   = 1'b0;
        chk_quiet("wr_after");
        chk_held("wr_after");
        @(posedge clk); #1;
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 64'hDEAD_DEAD_DEAD_DEAD;
        @(negedge clk);
        chk_quiet("wr_stray");
        @(posedge clk); #1;
        bus.mem_resp_valid = 1'b0;
        @(negedge clk);
        chk_quiet("wr_stray_next");
        chk_held("wr_stray_next");

        // After the mid-transaction reset LSU again wins a tie
        txn(1, 1, 64'hE000_0000, 64'hE000_0100, 0, 64'd0, 8'd0, 0, 0, 64'h1234_5678_9ABC_DEF0);
        chk("post_rst_lsu_first", last_lsu, 1);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            r  = $urandom_range(1, 3);
            iv = (r & 1) != 0;
            lv = (r & 2) != 0;
            a  = {$urandom, $urandom};
            txn(iv, lv, a, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                {$urandom, $urandom}, 8'($urandom),
                $urandom_range(0, 6), $urandom_range(0, 6), {$urandom, $urandom});
        end

        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk_quiet("end");
        chk_held("end");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
